// File: rtl/servo_pwm_if.sv
// Position-command handshake between upstream logic and the servo PWM generator.
interface servo_pwm_if #(
  parameter int POS_W = 8
);
  logic [POS_W-1:0] pos_in;
  logic             pos_valid;
  logic             pos_ready;

  modport master (output pos_in, output pos_valid, input  pos_ready);
  modport slave  (input  pos_in, input  pos_valid, output pos_ready);
endinterface

// File: rtl/servo_pwm.sv
// 50 Hz hobby-servo PWM: pulse width proportional to the active position,
// new positions and enable applied only at frame boundaries.
module servo_pwm #(
  parameter int unsigned CLK_HZ   = 25_000_000,
  parameter int unsigned FRAME_US = 20000,
  parameter int unsigned MIN_US   = 1000,
  parameter int unsigned MAX_US   = 2000,
  parameter int unsigned POS_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  servo_pwm_if.slave       pos,
  input  logic             en,
  output logic             servo_pin,
  output logic             frame_start
);
  localparam int unsigned CYC_PER_US = CLK_HZ / 1_000_000;
  localparam int unsigned FRAME_CYC  = CYC_PER_US * FRAME_US;
  localparam int unsigned MIN_CYC    = CYC_PER_US * MIN_US;
  localparam int unsigned STEP_CYC   = (CYC_PER_US * (MAX_US - MIN_US)) / ((2 ** POS_W) - 1);
  localparam int unsigned CNT_W      = $clog2(FRAME_CYC);
  localparam int unsigned PROD_W     = CNT_W + POS_W;

  logic [CNT_W-1:0]  cnt;
  logic [POS_W-1:0]  active_pos;
  logic [POS_W-1:0]  pend_pos;
  logic              pend_full;
  logic              en_frame;
  logic              last;
  logic              accept;
  logic [PROD_W-1:0] width_cyc;

  always_comb begin
    last          = (cnt == CNT_W'(FRAME_CYC - 1));
    accept        = pos.pos_valid && !pend_full;
    pos.pos_ready = !pend_full;
    // Product kept CNT_W+POS_W wide so full scale can never wrap.
    width_cyc     = PROD_W'(MIN_CYC) + PROD_W'(active_pos) * PROD_W'(STEP_CYC);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      active_pos  <= {1'b1, {(POS_W-1){1'b0}}};
      pend_pos    <= '0;
      pend_full   <= 1'b0;
      en_frame    <= 1'b0;
      servo_pin   <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      cnt <= last ? '0 : cnt + CNT_W'(1);

      if (last) begin
        en_frame <= en;
        if (pend_full) begin
          active_pos <= pend_pos;
        end
      end

      // A full slot blocks accept, so a boundary transfer and a capture never collide.
      if (last && pend_full) begin
        pend_full <= 1'b0;
      end else if (accept) begin
        pend_pos  <= pos.pos_in;
        pend_full <= 1'b1;
      end

      servo_pin   <= en_frame && ({{POS_W{1'b0}}, cnt} < width_cyc);
      frame_start <= (cnt == '0);
    end
  end
endmodule

// File: tb/tb_servo_pwm.sv
// Randomized self-checking bench for servo_pwm with a frame-level schedule model.
module tb_servo_pwm;
  localparam int CLK_HZ   = 2_000_000;
  localparam int FRAME_US = 500;
  localparam int MIN_US   = 50;
  localparam int MAX_US   = 350;
  localparam int POS_W    = 8;

  localparam int F        = (CLK_HZ / 1_000_000) * FRAME_US;
  localparam int MIN_CYC  = (CLK_HZ / 1_000_000) * MIN_US;
  localparam int STEP_CYC = ((CLK_HZ / 1_000_000) * (MAX_US - MIN_US)) / ((1 << POS_W) - 1);
  localparam int NF       = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;
  logic servo_pin;
  logic frame_start;

  servo_pwm_if #(.POS_W(POS_W)) bus ();

  servo_pwm #(
    .CLK_HZ(CLK_HZ), .FRAME_US(FRAME_US), .MIN_US(MIN_US), .MAX_US(MAX_US), .POS_W(POS_W)
  ) dut (
    .clk(clk), .rst(rst), .pos(bus), .en(en), .servo_pin(servo_pin), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: t counts cycles from the first cycle of frame 0 after reset release.
  int t;
  int busy_from, busy_to;
  int sched_pos [NF];
  bit sched_en  [NF];
  int next_chk, last_sched;

  // Observed frames, keyed by frame_start.
  int fidx = -1;
  int obs_high [NF];
  int obs_len  [NF];
  bit obs_rise_bad [NF];
  logic pin_q = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      fidx  = -1;
      pin_q = 1'b0;
    end else begin
      if (frame_start === 1'b1 && fidx < NF - 1) begin
        fidx++;
        obs_high[fidx] = 0;
        obs_len[fidx]  = 0;
        obs_rise_bad[fidx] = 1'b0;
      end
      if (fidx >= 0) begin
        obs_len[fidx]++;
        if (servo_pin === 1'b1) obs_high[fidx]++;
        if (servo_pin === 1'b1 && pin_q !== 1'b1 && frame_start !== 1'b1) obs_rise_bad[fidx] = 1'b1;
      end
      pin_q = servo_pin;
    end
  end

  function automatic int exp_width(input int k);
    return sched_en[k] ? MIN_CYC + sched_pos[k] * STEP_CYC : 0;
  endfunction

  function automatic bit model_ready();
    return !(t >= busy_from && t <= busy_to);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    t++;
  endtask

  task automatic wait_until(input int target);
    int g = 0;
    while (t < target && g < 4 * F) begin
      tick();
      g++;
    end
  endtask

  task automatic wait_frame(input int k, output bit done);
    int g = 0;
    while (fidx <= k && g < 3 * F) begin
      tick();
      g++;
    end
    done = (fidx > k);
  endtask

  task automatic reset_model();
    t = 0;
    busy_from = 1;
    busy_to = 0;
    next_chk = 0;
    last_sched = 0;
    for (int k = 0; k < NF; k++) begin
      sched_pos[k] = 1 << (POS_W - 1);
      sched_en[k]  = (k == 0) ? 1'b0 : en;
    end
  endtask

  // Holds pos_valid until the model says the slot is free; checks pos_ready meanwhile.
  task automatic send_pos(input int p);
    int g = 0;
    int ta, b;
    bus.pos_in    = 8'(p);
    bus.pos_valid = 1'b1;
    while (!model_ready() && g < 3 * F) begin
      n_cmp++;
      if (bus.pos_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL ready_held t=%0d: pos_ready=%b, required 0", t, bus.pos_ready);
      end
      tick();
      g++;
    end
    n_cmp++;
    if (bus.pos_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL ready_open t=%0d: pos_ready=%b, required 1", t, bus.pos_ready);
    end
    ta = t;
    b  = (ta % F == F - 1) ? ta + F : (ta / F) * F + F - 1;
    busy_from = ta + 1;
    busy_to   = b;
    last_sched = b / F + 1;
    for (int k = last_sched; k < NF; k++) sched_pos[k] = p;
    tick();
    bus.pos_valid = 1'b0;
    bus.pos_in    = 8'($urandom);
  endtask

  task automatic set_en(input bit v);
    en = v;
    for (int k = (t + F) / F; k < NF; k++) sched_en[k] = v;
  endtask

  task automatic check_frames_upto(input int last, input string name);
    bit done;
    for (int k = next_chk; k <= last; k++) begin
      wait_frame(k, done);
      n_cmp++;
      if (!done || obs_high[k] !== exp_width(k) || obs_len[k] !== F || obs_rise_bad[k]) begin
        n_bad++;
        $display("FAIL %s frame%0d: done=%0d high=%0d len=%0d rise_bad=%0d, required high=%0d len=%0d rise_bad=0",
                 name, k, done, obs_high[k], obs_len[k], obs_rise_bad[k], exp_width(k), F);
      end
    end
    if (last + 1 > next_chk) next_chk = last + 1;
  endtask

  task automatic test_reset();
    bus.pos_valid = 1'b1;
    bus.pos_in    = 8'd7;
    en  = 1'b1;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (servo_pin !== 1'b0 || frame_start !== 1'b0 || bus.pos_ready !== 1'b1) begin
        n_bad++;
        $display("FAIL reset_state cyc%0d: pin=%b fs=%b ready=%b, required 0 0 1",
                 i, servo_pin, frame_start, bus.pos_ready);
      end
    end
    bus.pos_valid = 1'b0;
    rst = 1'b0;
    reset_model();
    tick();
    n_cmp++;
    if (bus.pos_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_no_capture: pos_ready=%b, required 1", bus.pos_ready);
    end
  endtask

  task automatic test_centre();
    check_frames_upto(2, "centre");
  endtask

  task automatic test_positions();
    send_pos(0);
    send_pos(255);
    repeat (4) begin
      repeat ($urandom_range(0, F - 1)) tick();
      send_pos($urandom_range(0, 255));
    end
    check_frames_upto(last_sched, "positions");
  endtask

  task automatic test_back_to_back();
    int n;
    int a;
    int b2;
    n = t / F + 1;
    wait_until(n * F + $urandom_range(1, F - 3));
    a  = $urandom_range(0, 127);
    b2 = $urandom_range(128, 255);
    send_pos(a);
    send_pos(b2);
    check_frames_upto(last_sched, "back_to_back");
  endtask

  task automatic test_boundary_accept();
    int n;
    while (!model_ready()) tick();
    n = t / F + 1;
    wait_until(n * F + F - 1);
    send_pos($urandom_range(0, 255));
    check_frames_upto(last_sched, "boundary_accept");
  endtask

  task automatic test_enable();
    int n;
    n = t / F + 1;
    wait_until(n * F + $urandom_range(1, exp_width(n) - 1));
    set_en(1'b0);
    wait_until((n + 1) * F + $urandom_range(1, F - 2));
    set_en(1'b1);
    check_frames_upto(n + 2, "enable");
  endtask

  task automatic test_mid_reset();
    int n;
    bit exp_pin;
    while (!model_ready()) tick();
    n = t / F + 1;
    wait_until(n * F + 20);
    send_pos($urandom_range(0, 255));
    wait_until(n * F + 60);
    exp_pin = sched_en[n] && exp_width(n) > 59;
    n_cmp++;
    if (servo_pin !== exp_pin) begin
      n_bad++;
      $display("FAIL pre_reset_pin: pin=%b, required %b", servo_pin, exp_pin);
    end
    rst = 1'b1;
    tick();
    n_cmp++;
    if (servo_pin !== 1'b0 || bus.pos_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_reset: pin=%b ready=%b, required 0 1", servo_pin, bus.pos_ready);
    end
    tick();
    tick();
    rst = 1'b0;
    reset_model();
    check_frames_upto(2, "after_reset");
  endtask

  initial begin
    bus.pos_valid = 1'b0;
    bus.pos_in    = '0;
    t = 0;
    test_reset();
    test_centre();
    test_positions();
    test_back_to_back();
    test_boundary_accept();
    test_enable();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
